// File: rtl/ventana_muestreo.sv
// Serial-line sampler for the oversampled low-pass filter stage: synchronises RxIn,
// samples it every DIV enabled cycles and emits a primed SAMPLES*OSF-bit window once per symbol.
module ventana_muestreo #(
  parameter int SAMPLES     = 2,
  parameter int OSF         = 8,
  parameter int DIV         = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     EN,
  input  logic                     ALIGN,
  input  logic                     RxIn,
  output logic [SAMPLES*OSF-1:0]   DataOut,
  output logic                     WinValid,
  output logic                     Primed
);

  localparam int N  = SAMPLES * OSF;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam int FW = $clog2(N + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OSF - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [DW-1:0]          div_cnt_r;
  logic [PW-1:0]          phase_r;
  logic [FW-1:0]          fill_r;
  logic [N-1:0]           shift_r;

  logic                   rx_s;
  logic                   tick_s;
  logic                   strobe_s;
  logic [DW-1:0]          div_next_s;
  logic [PW-1:0]          phase_next_s;
  logic [FW-1:0]          fill_inc_s;
  logic [FW-1:0]          fill_next_s;
  logic [N-1:0]           shift_inc_s;
  logic [N-1:0]           shift_next_s;

  // Saturating fill increment: the fill count never exceeds the window length.
  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] val);
    logic [FW-1:0] res;
    if (val == FILL_MAX) begin
      res = FILL_MAX;
    end else begin
      res = val + FW'(1);
    end
    return res;
  endfunction

  assign rx_s   = sync_r[SYNC_STAGES-1];
  assign tick_s = EN && (div_cnt_r == DIV_LAST);

  // Next-state for prescaler, symbol phase, fill and shift; ALIGN overrides any tick.
  always_comb begin
    div_next_s   = div_cnt_r;
    phase_next_s = phase_r;
    fill_inc_s   = sat_inc(fill_r);
    fill_next_s  = fill_r;
    shift_inc_s  = {shift_r[N-2:0], rx_s};
    shift_next_s = shift_r;
    strobe_s     = 1'b0;
    if (ALIGN) begin
      div_next_s   = '0;
      phase_next_s = '0;
      fill_next_s  = '0;
      shift_next_s = '0;
    end else if (tick_s) begin
      div_next_s   = '0;
      phase_next_s = (phase_r == PH_LAST) ? '0 : phase_r + PW'(1);
      fill_next_s  = fill_inc_s;
      shift_next_s = shift_inc_s;
      strobe_s     = (phase_r == PH_LAST) && (fill_inc_s == FILL_MAX);
    end else if (EN) begin
      div_next_s   = div_cnt_r + DW'(1);
    end else begin
      div_next_s   = div_cnt_r;
    end
  end

  // Synchroniser chain runs every cycle, independent of EN and ALIGN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], RxIn};
    end
  end

  // Sampling state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_r <= '0;
      phase_r   <= '0;
      fill_r    <= '0;
      shift_r   <= '0;
    end else begin
      div_cnt_r <= div_next_s;
      phase_r   <= phase_next_s;
      fill_r    <= fill_next_s;
      shift_r   <= shift_next_s;
    end
  end

  // Registered outputs; DataOut only moves on a strobe so it is stable for a whole symbol.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DataOut  <= '0;
      WinValid <= 1'b0;
      Primed   <= 1'b0;
    end else begin
      WinValid <= strobe_s;
      Primed   <= (fill_next_s == FILL_MAX);
      if (strobe_s) begin
        DataOut <= shift_inc_s;
      end else begin
        DataOut <= DataOut;
      end
    end
  end

endmodule
